// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern path: serializer state encoding
// and the default pattern width.
package seq_pkg;

    localparam int PAT_W = 5;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in serial-out converter with a one-entry holding register so that
// words can stream back to back without idle cycles on sout.
module piso_serializer
    import seq_pkg::*;
#(
    parameter int WIDTH      = PAT_W,
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             sout_last,
    output logic             busy
);

    localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    state_t           state_r, state_s;
    logic [WIDTH-1:0] sr_r, sr_s;
    logic [WIDTH-1:0] hr_r, hr_s;
    logic             hr_full_r, hr_full_s;
    logic [CW-1:0]    cnt_r, cnt_s;
    logic             accept_s;
    logic             free_s;
    logic             sout_r, sout_valid_r, sout_last_r, busy_r;

    // Bit that leaves the shift register first, given the configured order.
    function automatic logic head_bit(input logic [WIDTH-1:0] v);
        if (MSB_FIRST) begin
            return v[WIDTH-1];
        end else begin
            return v[0];
        end
    endfunction

    // Advance the shift register by one bit toward the output end.
    function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] v);
        if (MSB_FIRST) begin
            return {v[WIDTH-2:0], 1'b0};
        end else begin
            return {1'b0, v[WIDTH-1:1]};
        end
    endfunction

    assign in_ready = !hr_full_r && !rst;

    // Next-state logic: the SR reloads at its free edge, HR before bypass.
    always_comb begin
        state_s   = state_r;
        sr_s      = sr_r;
        hr_s      = hr_r;
        hr_full_s = hr_full_r;
        cnt_s     = cnt_r;
        accept_s  = in_valid && in_ready;
        free_s    = (state_r == IDLE) || (cnt_r == LAST_CNT);

        if (free_s) begin
            cnt_s = {CW{1'b0}};
            if (hr_full_r) begin
                // in_ready was low, so accept_s is 0 here; HR simply drains.
                sr_s      = hr_r;
                state_s   = SHIFT;
                hr_full_s = accept_s;
                if (accept_s) begin
                    hr_s = in_data;
                end else begin
                    hr_s = hr_r;
                end
            end else if (accept_s) begin
                sr_s    = in_data;
                state_s = SHIFT;
            end else begin
                state_s = IDLE;
            end
        end else begin
            sr_s  = shift_once(sr_r);
            cnt_s = cnt_r + 1'b1;
            if (accept_s) begin
                hr_s      = in_data;
                hr_full_s = 1'b1;
            end else begin
                hr_full_s = hr_full_r;
            end
        end
    end

    // State, datapath and registered outputs; reset drops any word in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            sr_r         <= {WIDTH{1'b0}};
            hr_r         <= {WIDTH{1'b0}};
            hr_full_r    <= 1'b0;
            cnt_r        <= {CW{1'b0}};
            sout_r       <= IDLE_LEVEL;
            sout_valid_r <= 1'b0;
            sout_last_r  <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            sr_r         <= sr_s;
            hr_r         <= hr_s;
            hr_full_r    <= hr_full_s;
            cnt_r        <= cnt_s;
            sout_r       <= (state_s == SHIFT) ? head_bit(sr_s) : IDLE_LEVEL;
            sout_valid_r <= (state_s == SHIFT);
            sout_last_r  <= (state_s == SHIFT) && (cnt_s == LAST_CNT);
            busy_r       <= (state_s == SHIFT) || hr_full_s;
        end
    end

    assign sout       = sout_r;
    assign sout_valid = sout_valid_r;
    assign sout_last  = sout_last_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench: two serializer instances (MSB-first/idle-0 and
// LSB-first/idle-1) share stimulus; expected bit streams are queued per word.
module tb_piso_serializer;

    logic       clk;
    logic       rst;
    logic [4:0] in_data;
    logic       in_valid;
    logic       in_ready0, sout0, sout_valid0, sout_last0, busy0;
    logic       in_ready1, sout1, sout_valid1, sout_last1, busy1;

    // Each entry is {bit, last}.
    logic [1:0] q0[$];
    logic [1:0] q1[$];

    int checks = 0;
    int errors = 0;

    piso_serializer #(.WIDTH(5), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_msb (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready0), .sout(sout0), .sout_valid(sout_valid0),
        .sout_last(sout_last0), .busy(busy0)
    );

    piso_serializer #(.WIDTH(5), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) u_lsb (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready1), .sout(sout1), .sout_valid(sout_valid1),
        .sout_last(sout_last1), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a word becomes five bits in the configured order, last on the 5th.
    task automatic push_word(input logic [4:0] w);
        for (int i = 0; i < 5; i++) begin
            q0.push_back({w[4-i], i == 4});
            q1.push_back({w[i], i == 4});
        end
    endtask

    // Words still owed to the stream: one in the shifter, possibly one held.
    function automatic int words_pending(input logic [1:0] q[$]);
        int n = 0;
        foreach (q[i]) if (q[i][0]) n++;
        return n;
    endfunction

    task automatic check_lane(input string tag, inout logic [1:0] q[$],
                              input logic s, input logic v, input logic l,
                              input logic b, input logic r, input logic idle_lvl);
        logic       exp_v;
        logic [1:0] e;
        exp_v = (q.size() != 0);
        chk({tag, "_valid"}, v, exp_v);
        chk({tag, "_busy"}, b, exp_v);
        chk({tag, "_ready"}, r, words_pending(q) < 2);
        if (exp_v) begin
            if (v) begin
                e = q.pop_front();
                chk({tag, "_bit"}, s, e[1]);
                chk({tag, "_last"}, l, e[0]);
            end
        end else begin
            chk({tag, "_idle_level"}, s, idle_lvl);
            chk({tag, "_idle_last"}, l, 1'b0);
        end
    endtask

    // Monitor: every cycle, compare both instances against their queues.
    always @(negedge clk) begin
        if (!rst) begin
            check_lane("msb", q0, sout0, sout_valid0, sout_last0, busy0, in_ready0, 1'b0);
            check_lane("lsb", q1, sout1, sout_valid1, sout_last1, busy1, in_ready1, 1'b1);
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic offer(input logic [4:0] w);
        bit acc = 1'b0;
        for (int i = 0; i < 30 && !acc; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = w;
            #1;
            if (in_ready0) begin
                push_word(w);
                acc = 1'b1;
            end
        end
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL accept_timeout: got no accept expected accept of %b", w);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_v0"}, sout_valid0, 1'b0);
        chk({tag, "_s0"}, sout0, 1'b0);
        chk({tag, "_l0"}, sout_last0, 1'b0);
        chk({tag, "_b0"}, busy0, 1'b0);
        chk({tag, "_r0"}, in_ready0, 1'b0);
        chk({tag, "_v1"}, sout_valid1, 1'b0);
        chk({tag, "_s1"}, sout1, 1'b1);
        chk({tag, "_r1"}, in_ready1, 1'b0);
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 5'b00000;
        #1;
        check_reset_outputs("reset");
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("ready_after_release0", in_ready0, 1'b1);
        chk("ready_after_release1", in_ready1, 1'b1);

        // Single word, then an idle gap.
        offer(5'b10110);
        idle(8);

        // Two words with in_valid held high: contiguous 10 bits.
        offer(5'b10110);
        offer(5'b01001);
        idle(12);

        // Three words back to back: third waits for the holding register.
        offer(5'b11001);
        offer(5'b00110);
        offer(5'b10101);
        idle(18);

        // LSB-first lane sees 1,1,0,0,0 for this word, then a 3-cycle gap.
        offer(5'b00011);
        idle(3);
        offer(5'b01110);
        idle(8);

        // Asynchronous reset after two bits of a word.
        offer(5'b11111);
        idle(2);
        #2 rst = 1'b1;
        q0.delete();
        q1.delete();
        #1;
        check_reset_outputs("async_reset");
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("ready_after_midreset0", in_ready0, 1'b1);
        idle(10);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            in_valid = ($urandom_range(0, 3) != 0);
            in_data  = 5'($urandom);
            #1;
            if (in_valid && in_ready0) push_word(in_data);
        end
        idle(20);

        chk("drained0", q0.size() == 0, 1'b1);
        chk("drained1", q1.size() == 0, 1'b1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 5, meaning parallel word width in bits (legal range 2..32).
REQ-002 SHALL have parameter MSB_FIRST, default 1, meaning 1 = bit WIDTH-1 is sent first, 0 = bit 0 is sent first.
REQ-003 SHALL have parameter IDLE_LEVEL, default 0, meaning the value driven on sout while sout_valid is low.
REQ-004 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous, active-high reset.
REQ-006 SHALL have port in_data, input, WIDTH, parallel word to serialize.
REQ-007 SHALL have port in_valid, input, 1, in_data is valid this cycle.
REQ-008 SHALL have port in_ready, output, 1, block accepts a word this cycle.
REQ-009 SHALL have port sout, output, 1, serial bit stream; connects to the sequence detector's din.
REQ-010 SHALL have port sout_valid, output, 1, sout carries a data bit this cycle.
REQ-011 SHALL have port sout_last, output, 1, sout carries the final bit of a word.
REQ-012 SHALL have port busy, output, 1, shift register or holding register occupied.

Function
REQ-013 SHALL accept a word at a rising edge where in_valid and in_ready are both high; no other condition transfers data.
REQ-014 SHALL contain a shift register (SR), a one-entry holding register (HR) and a bit counter 0..WIDTH-1.
REQ-015 SHALL implement two states: IDLE (SR empty) and SHIFT (SR emitting).
REQ-016 SHALL drive in_ready as the combinational value !HR_full, derived only from registers (no path from in_valid), and forced 0 while rst is high.
REQ-017 SHALL load SR ("SR free edge") at an edge where state is IDLE, or where state is SHIFT with bit counter = WIDTH-1; source priority is HR if full, otherwise an incoming accepted word (bypass); when neither is available, go or stay IDLE.
REQ-018 SHALL write an accepted word into HR when the word is not bypassed into SR at the same edge.
REQ-019 SHALL drive sout, sout_valid and sout_last from registers; the first bit of a word accepted at edge k in IDLE appears in the cycle following edge k (1-cycle latency).
REQ-020 SHALL present exactly one bit per clock for WIDTH consecutive cycles per word, ordered per MSB_FIRST, with sout_valid high throughout.
REQ-021 SHALL assert sout_last only in the cycle carrying the word's final bit.
REQ-022 SHALL stream back-to-back words with no idle cycle whenever HR is full or a word is accepted at the SR free edge.
REQ-023 SHALL, when idle, hold sout = IDLE_LEVEL, sout_valid = 0 and sout_last = 0.
REQ-024 SHALL assert busy when state is SHIFT or HR is full.
REQ-025 SHALL, on simultaneous HR drain to SR and a new accept at the same edge, load HR with the new word (in_ready was high only if HR was empty, so no overwrite occurs).

Reset
REQ-026 SHALL, while rst is high, clear the state to IDLE, HR_full to 0 and the bit counter to 0, and drive sout = IDLE_LEVEL, sout_valid = 0, sout_last = 0, busy = 0 and in_ready = 0.
REQ-027 SHALL discard any partially sent word and the HR contents on reset mid-operation; no residual bits are emitted after release.
REQ-028 SHALL raise in_ready in the first cycle after rst is deasserted.

Structure
REQ-029 SHALL place the state encoding (IDLE, SHIFT) in a shared package seq_pkg, alongside the default pattern width constant PAT_W = 5.
REQ-030 SHALL be a single module with no sub-modules; the holding register is inline.

Verification
REQ-031 SHALL cover: WIDTH=5, MSB_FIRST=1, a single word 5'b10110 -> sout = 1,0,1,1,0 on 5 consecutive cycles starting one cycle after accept, sout_last on the 5th, and a downstream sequence detector's dout asserted.
REQ-032 SHALL cover: words 5'b10110 and 5'b01001 with in_valid held high -> 10 contiguous valid bits 1011001001, no gap, and two sout_last pulses.
REQ-033 SHALL cover: three words offered back-to-back -> in_ready drops after the 2nd accept, the 3rd is accepted when HR drains, output 15 contiguous bits, and no word lost or duplicated.
REQ-034 SHALL cover: rst asserted asynchronously after 2 bits of 5'b11111 -> sout_valid = 0 and sout = IDLE_LEVEL immediately, and no further bits after release.
REQ-035 SHALL cover: MSB_FIRST=0 with word 5'b00011 -> sout = 1,1,0,0,0; then an idle gap of 3 cycles -> sout_valid = 0 and sout = IDLE_LEVEL.
